// File: rtl/sd_clk_pkg.sv
// Shared SD clock definitions: speed codes, controller state encoding and counter width.
// Reused by the SD host controller, so changes here ripple beyond sd_clk_ctrl.
package sd_clk_pkg;

   localparam int NUM_SPEEDS = 5;
   localparam int CNT_W      = 10;

   typedef enum logic [2:0] {
      SPD_400K = 3'd0,
      SPD_25M  = 3'd1,
      SPD_50M  = 3'd2,
      SPD_100M = 3'd3,
      SPD_200M = 3'd4
   } speed_t;

   localparam logic [2:0] SPD_MAX = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GATE   = 2'd1,
      ST_ENABLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Mux select pattern for a legal speed code.
   function automatic logic [NUM_SPEEDS-1:0] speed_onehot(input speed_t s);
      speed_onehot = NUM_SPEEDS'(1) << s;
   endfunction

endpackage

// File: rtl/sd_clk_ctrl.sv
// SD card clock speed switcher: gates all mux enables for a guard interval, enables the
// new source, waits for it to settle, then acknowledges. Every output is registered.
module sd_clk_ctrl
   import sd_clk_pkg::*;
#(
   parameter int GUARD_CYC  = 64,
   parameter int SETTLE_CYC = 128
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       I_REQ,
   input  logic [2:0] I_SPEED,
   output logic       O_BUSY,
   output logic       O_ACK,
   output logic       O_ERR,
   output logic [2:0] O_CUR_SPEED,
   output logic       O_EN_400K,
   output logic       O_EN_25M,
   output logic       O_EN_50M,
   output logic       O_EN_100M,
   output logic       O_EN_200M
);

   localparam logic [CNT_W-1:0] GUARD_LOAD  = CNT_W'(GUARD_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

   state_t                  state_reg;
   logic [CNT_W-1:0]        cnt_reg;
   speed_t                  tgt_reg;
   speed_t                  cur_reg;
   logic [NUM_SPEEDS-1:0]   en_reg;
   logic                    ack_reg;
   logic                    err_reg;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         tgt_reg   <= SPD_400K;
         cur_reg   <= SPD_400K;
         en_reg    <= speed_onehot(SPD_400K);
         ack_reg   <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         ack_reg <= 1'b0;
         err_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (I_REQ) begin
                  if (I_SPEED > SPD_MAX) begin
                     err_reg <= 1'b1;
                  end else if (I_SPEED == cur_reg) begin
                     cnt_reg   <= '0;
                     state_reg <= ST_DONE;
                  end else begin
                     tgt_reg   <= speed_t'(I_SPEED);
                     en_reg    <= '0;
                     cnt_reg   <= GUARD_LOAD;
                     state_reg <= ST_GATE;
                  end
               end
            end
            ST_GATE: begin
               if (cnt_reg == '0) begin
                  en_reg    <= speed_onehot(tgt_reg);
                  cur_reg   <= tgt_reg;
                  cnt_reg   <= SETTLE_LOAD;
                  state_reg <= ST_ENABLE;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            ST_ENABLE: begin
               if (cnt_reg == '0) begin
                  state_reg <= ST_DONE;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            ST_DONE: begin
               // Ack lands as DONE retires, so it coincides with BUSY dropping.
               ack_reg   <= 1'b1;
               state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign O_BUSY      = (state_reg != ST_IDLE);
   assign O_ACK       = ack_reg;
   assign O_ERR       = err_reg;
   assign O_CUR_SPEED = cur_reg;
   assign O_EN_400K   = en_reg[SPD_400K];
   assign O_EN_25M    = en_reg[SPD_25M];
   assign O_EN_50M    = en_reg[SPD_50M];
   assign O_EN_100M   = en_reg[SPD_100M];
   assign O_EN_200M   = en_reg[SPD_200M];

endmodule

// File: tb/tb_sd_clk_ctrl.sv
// Directed bench for sd_clk_ctrl: reset, speed change, illegal code, same speed,
// ignored request while busy, reset abort, plus a free-running one-hot monitor.
module tb_sd_clk_ctrl;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       I_REQ = 1'b0;
   logic [2:0] I_SPEED = 3'd0;
   logic       O_BUSY, O_ACK, O_ERR;
   logic [2:0] O_CUR_SPEED;
   logic       O_EN_400K, O_EN_25M, O_EN_50M, O_EN_100M, O_EN_200M;
   logic [4:0] en;

   int n_vec = 0;
   int n_bad = 0;
   int onehot_viol = 0;
   int both_viol = 0;
   int ack_cnt = 0;
   int err_cnt = 0;

   sd_clk_ctrl #(.GUARD_CYC(64), .SETTLE_CYC(128)) dut (
      .CLK(CLK), .RST(RST), .I_REQ(I_REQ), .I_SPEED(I_SPEED),
      .O_BUSY(O_BUSY), .O_ACK(O_ACK), .O_ERR(O_ERR), .O_CUR_SPEED(O_CUR_SPEED),
      .O_EN_400K(O_EN_400K), .O_EN_25M(O_EN_25M), .O_EN_50M(O_EN_50M),
      .O_EN_100M(O_EN_100M), .O_EN_200M(O_EN_200M)
   );

   assign en = {O_EN_200M, O_EN_100M, O_EN_50M, O_EN_25M, O_EN_400K};

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if ($countones(en) > 1) onehot_viol++;
      if (O_ACK && O_ERR) both_viol++;
      if (!RST && O_ACK) ack_cnt++;
      if (!RST && O_ERR) err_cnt++;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b1; I_REQ = 1'b0;
      repeat (3) tick();
      n_vec++;
      if (en !== 5'b00001 || O_CUR_SPEED !== 3'd0 || O_BUSY !== 1'b0 || O_ACK !== 1'b0 || O_ERR !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_hold: en=%b cur=%0d busy=%b ack=%b err=%b, want en=00001 cur=0 busy=0 ack=0 err=0",
                  en, O_CUR_SPEED, O_BUSY, O_ACK, O_ERR);
      end
      RST = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         n_vec++;
         if (en !== 5'b00001 || O_CUR_SPEED !== 3'd0 || O_BUSY !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle c%0d: en=%b cur=%0d busy=%b, want 00001/0/0", c, en, O_CUR_SPEED, O_BUSY);
         end
      end
      $display("reset: released and idle at 400K for 20 cycles");
   endtask

   task automatic test_same_speed();
      int a0;
      a0 = ack_cnt;
      I_SPEED = 3'd0; I_REQ = 1'b1;
      tick(); I_REQ = 1'b0;
      n_vec++;
      if (O_BUSY !== 1'b1 || O_ACK !== 1'b0 || en !== 5'b00001) begin
         n_bad++;
         $display("FAIL same_c1: busy=%b ack=%b en=%b, want 1/0/00001", O_BUSY, O_ACK, en);
      end
      tick();
      n_vec++;
      if (O_ACK !== 1'b1 || O_BUSY !== 1'b0 || en !== 5'b00001) begin
         n_bad++;
         $display("FAIL same_c2: ack=%b busy=%b en=%b, want 1/0/00001", O_ACK, O_BUSY, en);
      end
      tick();
      n_vec++;
      if (O_ACK !== 1'b0 || ack_cnt - a0 !== 1) begin
         n_bad++;
         $display("FAIL same_pulse: ack=%b pulses=%0d, want 0/1", O_ACK, ack_cnt - a0);
      end
      $display("same_speed: request 0 at 400K acked at cycle 2");
   endtask

   task automatic test_change_25m();
      int zero_cyc, ack_cyc, a0;
      logic [4:0] en65;
      logic [2:0] cur65;
      logic busy193, busy194;
      zero_cyc = 0; ack_cyc = 0; a0 = ack_cnt;
      en65 = '0; cur65 = '0; busy193 = 1'b0; busy194 = 1'b1;
      I_SPEED = 3'd1; I_REQ = 1'b1;
      tick(); I_REQ = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         if (c <= 64 && en == 5'b00000) zero_cyc++;
         if (c == 65) begin en65 = en; cur65 = O_CUR_SPEED; end
         if (c == 193) busy193 = O_BUSY;
         if (c == 194) busy194 = O_BUSY;
         if (O_ACK && ack_cyc == 0) ack_cyc = c;
         tick();
      end
      n_vec++;
      if (zero_cyc !== 64) begin
         n_bad++; $display("FAIL chg_gate: zero-enable cycles=%0d, want 64", zero_cyc);
      end
      n_vec++;
      if (en65 !== 5'b00010 || cur65 !== 3'd1) begin
         n_bad++; $display("FAIL chg_enable: en=%b cur=%0d at c65, want 00010/1", en65, cur65);
      end
      n_vec++;
      if (ack_cyc !== 194) begin
         n_bad++; $display("FAIL chg_ack_cycle: ack at %0d, want 194", ack_cyc);
      end
      n_vec++;
      if (busy193 !== 1'b1 || busy194 !== 1'b0 || ack_cnt - a0 !== 1) begin
         n_bad++;
         $display("FAIL chg_busy: busy193=%b busy194=%b pulses=%0d, want 1/0/1", busy193, busy194, ack_cnt - a0);
      end
      $display("change_25m: ack cycle %0d, gate cycles %0d", ack_cyc, zero_cyc);
   endtask

   task automatic test_illegal();
      int a0;
      a0 = ack_cnt;
      I_SPEED = 3'd6; I_REQ = 1'b1;
      tick(); I_REQ = 1'b0;
      n_vec++;
      if (O_ERR !== 1'b1 || O_ACK !== 1'b0 || O_BUSY !== 1'b0 || en !== 5'b00010 || O_CUR_SPEED !== 3'd1) begin
         n_bad++;
         $display("FAIL illegal_c1: err=%b ack=%b busy=%b en=%b cur=%0d, want 1/0/0/00010/1",
                  O_ERR, O_ACK, O_BUSY, en, O_CUR_SPEED);
      end
      tick();
      n_vec++;
      if (O_ERR !== 1'b0 || O_BUSY !== 1'b0 || ack_cnt !== a0) begin
         n_bad++; $display("FAIL illegal_c2: err=%b busy=%b acks=%0d, want 0/0/0", O_ERR, O_BUSY, ack_cnt - a0);
      end
      $display("illegal: code 6 rejected, speed stays 25M");
   endtask

   task automatic test_back_to_back();
      int ack_cyc, e0;
      ack_cyc = 0; e0 = err_cnt;
      I_SPEED = 3'd4; I_REQ = 1'b1;
      tick(); I_REQ = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         if (O_ACK && ack_cyc == 0) ack_cyc = c;
         if (c == 10) begin I_REQ = 1'b1; I_SPEED = 3'd2; end
         else I_REQ = 1'b0;
         tick();
      end
      n_vec++;
      if (ack_cyc !== 194 || err_cnt !== e0) begin
         n_bad++; $display("FAIL b2b_ack: ack at %0d errs=%0d, want 194/0", ack_cyc, err_cnt - e0);
      end
      n_vec++;
      if (O_CUR_SPEED !== 3'd4 || en !== 5'b10000 || O_BUSY !== 1'b0) begin
         n_bad++; $display("FAIL b2b_final: cur=%0d en=%b busy=%b, want 4/10000/0", O_CUR_SPEED, en, O_BUSY);
      end
      $display("back_to_back: second request ignored, landed on 200M");
   endtask

   task automatic test_reset_abort();
      int a0, e0;
      a0 = ack_cnt; e0 = err_cnt;
      I_SPEED = 3'd1; I_REQ = 1'b1;
      tick(); I_REQ = 1'b0;
      repeat (9) tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      n_vec++;
      if (en !== 5'b00001 || O_CUR_SPEED !== 3'd0 || O_BUSY !== 1'b0 || O_ACK !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_now: en=%b cur=%0d busy=%b ack=%b, want 00001/0/0/0", en, O_CUR_SPEED, O_BUSY, O_ACK);
      end
      repeat (250) tick();
      n_vec++;
      if (ack_cnt !== a0 || err_cnt !== e0 || O_BUSY !== 1'b0 || en !== 5'b00001) begin
         n_bad++;
         $display("FAIL abort_after: acks=%0d errs=%0d busy=%b en=%b, want 0/0/0/00001",
                  ack_cnt - a0, err_cnt - e0, O_BUSY, en);
      end
      $display("reset_abort: gate aborted at cycle 10, back to 400K");
   endtask

   task automatic test_reset_vs_req();
      RST = 1'b1; I_REQ = 1'b1; I_SPEED = 3'd3;
      tick();
      RST = 1'b0; I_REQ = 1'b0;
      tick();
      n_vec++;
      if (O_BUSY !== 1'b0 || O_CUR_SPEED !== 3'd0 || en !== 5'b00001) begin
         n_bad++; $display("FAIL rst_vs_req: busy=%b cur=%0d en=%b, want 0/0/00001", O_BUSY, O_CUR_SPEED, en);
      end
      $display("reset_vs_req: request during reset discarded");
   endtask

   task automatic test_monitors();
      n_vec++;
      if (onehot_viol !== 0) begin
         n_bad++; $display("FAIL onehot: %0d violations, want 0", onehot_viol);
      end
      n_vec++;
      if (both_viol !== 0) begin
         n_bad++; $display("FAIL ack_err_overlap: %0d cycles, want 0", both_viol);
      end
      $display("monitors: onehot=%0d overlap=%0d", onehot_viol, both_viol);
   endtask

   initial begin
      test_reset();
      test_same_speed();
      test_change_25m();
      test_illegal();
      test_back_to_back();
      test_reset_abort();
      test_reset_vs_req();
      test_monitors();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/sd_clk_ctrl.md
SD_CLK_CTRL -- requirements
Module: sd_clk_ctrl

Interface
REQ-001 SHALL have parameter GUARD_CYC, default 64, meaning CLK cycles with all clock enables low before the new enable is asserted (legal range 1..1023).
REQ-002 SHALL have parameter SETTLE_CYC, default 128, meaning CLK cycles the new enable is held before acknowledge (legal range 1..1023).
REQ-003 SHALL have port CLK  in  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port I_REQ  in  1  speed-change request strobe, sampled only in IDLE.
REQ-006 SHALL have port I_SPEED  in  3  requested speed code: 0=400K, 1=25M, 2=50M, 3=100M, 4=200M; 5..7 illegal.
REQ-007 SHALL have port O_BUSY  out  1  high in every state except IDLE.
REQ-008 SHALL have port O_ACK  out  1  one-cycle pulse when the requested speed is active and settled.
REQ-009 SHALL have port O_ERR  out  1  one-cycle pulse when the request is rejected.
REQ-010 SHALL have port O_CUR_SPEED  out  3  code of the currently active speed.
REQ-011 SHALL have ports O_EN_400K, O_EN_25M, O_EN_50M, O_EN_100M, O_EN_200M  out  1 each  registered mux select enables, at most one high.

Function
REQ-012 SHALL implement the states IDLE, GATE, ENABLE and DONE.
REQ-013 In IDLE with I_REQ=1 and I_SPEED<=4 and I_SPEED!=O_CUR_SPEED, SHALL latch I_SPEED, drive all enables low on the next edge and go to GATE.
REQ-014 In IDLE with I_REQ=1 and I_SPEED==O_CUR_SPEED, SHALL go directly to DONE and leave the enables unchanged.
REQ-015 In IDLE with I_REQ=1 and I_SPEED>4, SHALL pulse O_ERR the next cycle, stay in IDLE and leave all other outputs unchanged.
REQ-016 GATE SHALL last exactly GUARD_CYC cycles with all enables low, then go to ENABLE.
REQ-017 On entry to ENABLE, SHALL assert only the enable for the latched code and update O_CUR_SPEED in the same cycle.
REQ-018 ENABLE SHALL last exactly SETTLE_CYC cycles, then go to DONE.
REQ-019 DONE SHALL last one cycle with O_ACK=1, then return to IDLE.
REQ-020 Request-to-ack latency SHALL be GUARD_CYC+SETTLE_CYC+2 cycles for a change and 2 cycles for a same-speed request.
REQ-021 I_REQ outside IDLE SHALL be ignored, with no queuing and no O_ERR.
REQ-022 SHALL use one shared down-counter, 10 bits wide, loaded with N-1 on state entry, with the state exiting at 0 and never wrapping.
REQ-023 The enables SHALL remain one-hot or all-zero in every cycle; two enables high at once is forbidden.
REQ-024 O_ACK and O_ERR SHALL never be high in the same cycle.

Reset
REQ-025 While RST=1, SHALL force state IDLE, counter 0, O_EN_400K=1, other enables 0, O_CUR_SPEED=0, and O_BUSY, O_ACK, O_ERR =0.
REQ-026 RST asserted mid-sequence SHALL abort it within one edge into the reset values, with no O_ACK and no O_ERR.
REQ-027 When RST takes priority over I_REQ in the same cycle, the request SHALL be discarded.

Structure
REQ-028 Speed codes 0..4, the state encoding and the counter width SHALL reside in shared package sd_clk_pkg, reused by the SD host controller.
REQ-029 The block SHALL be a single module with no sub-module, with the enables driving the SD clock mux select inputs directly.
REQ-030 The block SHALL contain no combinational path from inputs to outputs.

Verification
REQ-031 Release RST and hold I_REQ=0 -> O_EN_400K=1, O_CUR_SPEED=0, O_BUSY=0 for 20 cycles.
REQ-032 I_REQ=1 with I_SPEED=1 (GUARD=64, SETTLE=128) -> enables all 0 for 64 cycles, then O_EN_25M=1, and O_ACK at cycle 194.
REQ-033 I_REQ=1 with I_SPEED=6 -> O_ERR pulse at cycle 1, enables and O_CUR_SPEED unchanged.
REQ-034 I_REQ=1 with I_SPEED=0 while at 400K -> O_ACK at cycle 2, O_EN_400K never drops.
REQ-035 Change to 4 with a second I_REQ (I_SPEED=2) during GATE -> second request ignored, ack with O_CUR_SPEED=4.
REQ-036 RST asserted at GATE cycle 10 -> next cycle O_EN_400K=1, IDLE, and no O_ACK; a one-hot checker on all scenarios reports zero violations.
